// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - opcode constants, fetch FSM encoding and reset NOP word
package instr_fetch_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_IDLE = 6'b111111;

  // Word held in the instruction register out of reset so the controller idles.
  localparam logic [31:0] NOP_WORD = {OP_IDLE, 26'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  function automatic logic is_idle_op(input logic [31:0] word);
    return word[31:26] == OP_IDLE;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory port and decode handshake bundle
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump;
  logic              branch_taken;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready,
    output instruction,
    output instr_valid,
    input  instr_ready,
    input  jump,
    input  branch_taken
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready,
    input  instruction,
    input  instr_valid,
    output instr_ready,
    output jump,
    output branch_taken
  );

endinterface

// File: rtl/instr_fetch_next_pc_sel.sv
// rtl/instr_fetch_next_pc_sel.sv - next PC select: jump over taken branch over sequential
module next_pc_sel
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [31:0]       instruction,
  input  logic              jump,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;
  logic              unused_opcode;

  // Jump keeps the upper region of the sequential PC and replaces the rest.
  assign jump_target   = {pc_plus4[ADDR_W-1:28], instruction[25:0], 2'b00};
  assign branch_offset = {{(ADDR_W-18){instruction[15]}}, instruction[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign unused_opcode = ^instruction[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, instruction memory request, instruction register
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;

  assign pc_inc = pc_q + ADDR_W'(4);
  assign accept = valid_q && bus.instr_ready;

  next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_sel (
    .pc_plus4     (pc_inc),
    .instruction  (instr_q),
    .jump         (bus.jump),
    .branch_taken (bus.branch_taken),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // jump/branch_taken only matter on the accept edge.
        if (accept) begin
          valid_d = 1'b0;
          if (is_idle_op(instr_q)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            pc_d    = next_pc;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Request is a pure decode of the state so reset drops it without a clock.
  assign bus.imem_req    = (state_q == ST_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign pc_plus4        = pc_inc;
  assign halted          = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a PC-rule model
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit j, input bit b);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b) begin
      off = $signed(w[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_ready   = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_ready  = 1'b0;
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  // Leaves the DUT in its first request cycle, sampled at a falling edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    model_pc = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] w, input bit j, input bit b);
    bus.imem_rdata = w;
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready   = 1'b0;
    bus.instr_ready  = 1'b1;
    bus.jump         = j;
    bus.branch_taken = b;
    step();
    idle_inputs();
    if (w[31:26] != 6'b111111) model_pc = model_next(model_pc, w, j, b);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    checks++;
    if (bus.instruction !== 32'hFC00_0000) begin failures++; $display("FAIL reset_instr: got %h expected fc000000", bus.instruction); end
    checks++;
    if (bus.instr_valid !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got valid=%b halted=%b expected 0 0", bus.instr_valid, halted);
    end
  endtask

  task automatic test_sequential();
    bit          exp_req;
    logic [31:0] exp_addr;
    do_reset();
    bus.imem_ready  = 1'b1;
    bus.imem_rdata  = 32'h0000_0020;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_req  = (i % 2 == 0);
      exp_addr = 32'(4 * (i / 2));
      checks++;
      if (bus.imem_req !== exp_req || bus.instr_valid !== !exp_req) begin
        failures++;
        $display("FAIL seq_pattern[%0d]: got req=%b valid=%b expected req=%b valid=%b", i, bus.imem_req, bus.instr_valid, exp_req, !exp_req);
      end
      checks++;
      if (exp_req && bus.imem_addr !== exp_addr) begin
        failures++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, bus.imem_addr, exp_addr);
      end else if (!exp_req && bus.instruction !== 32'h0000_0020) begin
        failures++; $display("FAIL seq_instr[%0d]: got %h expected 00000020", i, bus.instruction);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_wait_hold();
    logic [31:0] w;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
        failures++; $display("FAIL wait_stable[%0d]: got req=%b addr=%h valid=%b expected 1 0 0", k, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      step();
    end
    w = 32'h1234_5678;
    bus.imem_rdata = w;
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== w || bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL wait_capture: got valid=%b instr=%h req=%b expected 1 %h 0", bus.instr_valid, bus.instruction, bus.imem_req, w);
    end
    for (int k = 0; k < 5; k++) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = $urandom;
      bus.jump       = 1'b1;
      step();
      checks++;
      if (bus.instruction !== w || bus.imem_req !== 1'b0 || pc !== 32'h0 || bus.instr_valid !== 1'b1) begin
        failures++; $display("FAIL hold_stable[%0d]: got instr=%h req=%b pc=%h valid=%b expected %h 0 0 1", k, bus.instruction, bus.imem_req, pc, bus.instr_valid, w);
      end
    end
    idle_inputs();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      failures++; $display("FAIL hold_release: got req=%b addr=%h expected 1 00000004", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_jump();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      repeat (4) fetch(32'h0000_0020, 1'b0, 1'b0);
      checks++;
      if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL jump_setup[%0d]: got %h expected 00000010", pass, bus.imem_addr); end
      fetch(32'h0800_0040, 1'b1, pass == 1);
      checks++;
      if (bus.imem_addr !== 32'h100 || model_pc !== 32'h100) begin
        failures++; $display("FAIL jump_target[%0d]: got %h expected 00000100 (model %h)", pass, bus.imem_addr, model_pc);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (8) fetch(32'h0000_0020, 1'b0, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h20) begin failures++; $display("FAIL br_setup: got %h expected 00000020", bus.imem_addr); end
    fetch(32'h1000_FFFE, 1'b0, 1'b1);
    checks++;
    if (bus.imem_addr !== 32'h1C) begin failures++; $display("FAIL br_taken: got %h expected 0000001c", bus.imem_addr); end
    fetch(32'h0000_0020, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 1'b0, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h24) begin failures++; $display("FAIL br_not_taken: got %h expected 00000024", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch(32'h1000_FFFE, 1'b0, 1'b1);
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      failures++; $display("FAIL wrap_setup: got addr=%h pc_plus4=%h expected fffffffc 00000000", bus.imem_addr, pc_plus4);
    end
    fetch(32'h0000_0020, 1'b0, 1'b0);
    checks++;
    if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
      failures++; $display("FAIL wrap_seq: got addr=%h req=%b expected 00000000 1", bus.imem_addr, bus.imem_req);
    end
  endtask

  task automatic test_halt();
    int busy;
    do_reset();
    fetch(32'h0000_0020, 1'b0, 1'b0);
    fetch(NOP_WORD, 1'b0, 1'b0);
    checks++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc !== 32'h4) begin
      failures++; $display("FAIL halt_enter: got halted=%b req=%b valid=%b pc=%h expected 1 0 0 00000004", halted, bus.imem_req, bus.instr_valid, pc);
    end
    busy = 0;
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || halted !== 1'b1) busy++;
    end
    checks++;
    if (busy != 0) begin failures++; $display("FAIL halt_stay: got %0d active cycles expected 0", busy); end
    do_reset();
    checks++;
    if (halted !== 1'b0 || bus.imem_req !== 1'b1) begin
      failures++; $display("FAIL halt_exit: got halted=%b req=%b expected 0 1", halted, bus.imem_req);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch(32'h0000_0020, 1'b0, 1'b0);
    fetch(32'h0000_0020, 1'b0, 1'b0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      failures++; $display("FAIL mid_setup: got req=%b addr=%h expected 1 00000008", bus.imem_req, bus.imem_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || pc !== 32'h0 || bus.instr_valid !== 1'b0 || bus.instruction !== NOP_WORD) begin
      failures++; $display("FAIL mid_reset: got req=%b pc=%h valid=%b instr=%h expected 0 0 0 fc000000", bus.imem_req, pc, bus.instr_valid, bus.instruction);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] w;
    bit          j, b;
    int          nw, nh;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 3);
      nh = $urandom_range(0, 2);
      w  = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 1) == 1);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc) begin
        failures++; $display("FAIL rnd_addr[%0d]: got req=%b addr=%h expected 1 %h", it, bus.imem_req, bus.imem_addr, model_pc);
      end
      for (int k = 0; k < nw; k++) step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc) begin
        failures++; $display("FAIL rnd_wait[%0d]: got req=%b addr=%h expected 1 %h", it, bus.imem_req, bus.imem_addr, model_pc);
      end
      bus.imem_rdata = w;
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      for (int k = 0; k < nh; k++) step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruction !== w || pc !== model_pc) begin
        failures++; $display("FAIL rnd_hold[%0d]: got valid=%b instr=%h pc=%h expected 1 %h %h", it, bus.instr_valid, bus.instruction, pc, w, model_pc);
      end
      bus.instr_ready  = 1'b1;
      bus.jump         = j;
      bus.branch_taken = b;
      step();
      idle_inputs();
      model_pc = model_next(model_pc, w, j, b);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_hold();
    test_jump();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the main decode controller. It owns the PC, issues word reads to instruction memory, and holds each fetched word in an instruction register. The decode controller consumes the word from that register through a valid/ready handshake. On each accepted instruction the PC advances sequentially or redirects on jump or taken branch. An accepted idle opcode (6'b111111) halts fetch until reset.

Parameters:
ADDR_W, 32, PC / instruction-memory byte-address width (instruction memory is word-addressed via addr[ADDR_W-1:2]).
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
imem_req  out  1  read request to instruction memory.
imem_addr  out  ADDR_W  byte address of request; equals pc.
imem_rdata  in  32  read data; valid in the cycle imem_ready=1.
imem_ready  in  1  memory completes the request this cycle.
instruction  out  32  instruction register, feeds controller.
instr_valid  out  1  instruction register holds an unconsumed word.
instr_ready  in  1  decode accepts instruction this cycle.
jump  in  1  accepted instruction is a jump (from controller Jump).
branch_taken  in  1  Branch AND ALU zero, for accepted instruction.
pc  out  ADDR_W  address of the word currently held or being fetched.
pc_plus4  out  ADDR_W  pc + 4, modulo 2^ADDR_W.
halted  out  1  fetch stopped on idle opcode.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; imem_req=0; instruction=32'hFC00_0000 (idle opcode, so the controller idles); instr_valid=0; halted=0; state=IDLE. An in-flight memory request is abandoned, and imem_req drops immediately.
- FSM states: IDLE, REQ, HOLD, HALT.
- IDLE: entered from reset only; moves to REQ on the first clk edge after reset deasserts.
- REQ: imem_req=1; imem_addr=pc is held stable until imem_ready. On an edge with imem_ready=1: instruction<=imem_rdata, instr_valid<=1, state->HOLD. Zero-wait memory therefore gives 1 cycle in REQ.
- HOLD: imem_req=0; instruction is stable. Accept occurs on an edge with instr_valid & instr_ready:
  - If instruction[31:26]==6'b111111: state->HALT, halted<=1, instr_valid<=0, pc unchanged.
  - Otherwise instr_valid<=0, state->REQ, and pc is loaded with next_pc.
- next_pc priority: jump > branch_taken > sequential.
  - jump: {pc_plus4[ADDR_W-1:28], instruction[25:0], 2'b00}.
  - branch_taken: pc_plus4 + (sign_extend(instruction[15:0]) << 2), modulo 2^ADDR_W.
  - else: pc_plus4.
- jump and branch_taken are sampled only on the accept edge and ignored at all other times.
- Throughput: 2 cycles per instruction minimum (REQ, HOLD). No prefetch, so no flush is ever needed.
- HALT: imem_req=0, instr_valid=0, halted=1. Only reset leaves HALT.
- Wrap-around: pc 32'hFFFF_FFFC with sequential advance gives 32'h0000_0000.
- imem_ready in IDLE, HOLD or HALT is ignored. instr_ready while instr_valid=0 is ignored.

Decomposition:
- Shared package: opcode constants (OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_J, OP_IDLE=6'b111111), shared with the controller; fetch FSM state encoding; the reset NOP word 32'hFC00_0000.
- One combinational sub-module, next_pc_sel, takes pc_plus4, instruction, jump and branch_taken and outputs next_pc. The FSM and registers stay in instr_fetch.

Test Plan:
- Reset release, imem_ready tied 1, rdata=32'h0000_0020, instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; instruction=32'h0000_0020.
- imem_ready delayed 3 cycles -> imem_req and imem_addr stay stable 3 cycles; instr_valid rises the cycle after ready.
- Word 32'h0800_0040 accepted with jump=1 at pc=0x10 -> next imem_addr=0x0000_0100. Same accept with branch_taken=1 as well -> jump wins.
- Word 32'h1000_FFFE (offset -2), branch_taken=1, pc=0x20 -> next addr 0x1C. branch_taken=0 -> next addr 0x24.
- instr_ready held 0 for 5 cycles in HOLD -> instruction stable, no imem_req, pc unchanged. Word 32'hFC00_0000 accepted -> halted=1, no further imem_req until reset.
- reset=0 asserted mid-REQ -> imem_req=0 the same cycle, pc=RESET_PC, instr_valid=0. pc=0xFFFF_FFFC sequential advance -> next imem_addr=0x0.
